hazard_tracker: RTL
===================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and all state SHALL be updated on its rising edge.
REQ-002 The block SHALL have one reset, `rst`, which is asynchronous and active-high.

Ports (name, direction, width, meaning):
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 id_valid  in  1  decode-stage instruction is valid.
REQ-006 id_rd  in  5  decode-stage destination register.
REQ-007 id_regWrite  in  1  decode-stage instruction writes rd.
REQ-008 id_memRead  in  1  decode-stage instruction is a load.
REQ-009 id_rs1, id_rs2  in  5 each  decode-stage source registers.
REQ-010 flush  in  1  branch/jump redirect resolved this cycle; the decode-stage instruction is wrong-path.
REQ-011 cnt_clear  in  1  synchronous clear of the stall counter.
REQ-012 rdEx, rdMem, rdWb  out  5 each  destination register held in the EX, MEM and WB stage tags.
REQ-013 regWriteEx, regWriteMem, regWriteWb  out  1 each  the corresponding stage holds a live register write.
REQ-014 stall  out  1  load-use stall request to the PC and IF/ID registers.
REQ-015 stall_count  out  16  saturating count of stall cycles.

Function
REQ-016 The block SHALL hold three tag registers: EX, MEM and WB; each tag SHALL be {valid, rd[4:0], regWrite, memRead}.
REQ-017 The raw load-use hazard SHALL be: id_valid & ex.valid & ex.memRead & ex.regWrite & (ex.rd != 0) & (ex.rd == id_rs1 | ex.rd == id_rs2).
REQ-018 stall SHALL equal raw load-use hazard & ~flush.
REQ-019 stall SHALL be combinational from the registered EX tag and the current ID inputs, with zero cycles of latency.
REQ-020 Each cycle, MEM SHALL load EX and WB SHALL load MEM unconditionally; stall and flush SHALL never hold MEM or WB.
REQ-021 EX SHALL load {id_valid, id_rd, id_regWrite, id_memRead} when neither flush nor stall is asserted.
REQ-022 EX SHALL load a bubble (valid=0, all other fields 0) when flush=1 or stall=1.
REQ-023 flush SHALL take priority over stall.
REQ-024 A stall SHALL insert exactly one bubble per asserted cycle; upstream holds the ID inputs, so the hazard clears after one bubble in the normal case.
REQ-025 regWriteX SHALL equal X.valid & X.regWrite & (X.rd != 0) for X in {Ex, Mem, Wb}.
REQ-026 rdX SHALL equal X.rd when X.valid=1, and 0 otherwise.
REQ-027 Writes to x0 SHALL never assert a regWrite output.
REQ-028 stall_count SHALL increment by 1 on each clock edge where stall=1.
REQ-029 stall_count SHALL saturate at 16'hFFFF and SHALL not wrap.
REQ-030 cnt_clear SHALL set stall_count to 0 on the next edge and SHALL take priority over increment when both apply in the same cycle.
REQ-031 When flush=1 and the raw hazard are both true in the same cycle, stall SHALL be 0 and the counter SHALL not increment.

Reset
REQ-032 While rst=1, all tags SHALL be invalid and zero, and stall_count SHALL be 0.
REQ-033 While rst=1, all outputs SHALL read 0, including stall.
REQ-034 Assertion of rst mid-operation SHALL discard all in-flight tags immediately, without waiting for a clock edge.
REQ-035 The first edge after rst deasserts SHALL load EX from the ID inputs normally.

Verification
REQ-036 Scenario – ALU chain: id (rd=5, regWrite=1) in cycle 0 -> regWriteEx=1/rdEx=5 in cycle 1, regWriteMem=1/rdMem=5 in cycle 2, regWriteWb=1/rdWb=5 in cycle 3, all 0 in cycle 4.
REQ-037 Scenario – load-use: load with rd=7 in EX, ID has rs2=7 -> stall=1 for one cycle, EX becomes a bubble, MEM holds rd=7, stall_count=1; with ID held, stall=0 on the next cycle.
REQ-038 Scenario – x0 load: load with rd=0 in EX, ID has rs1=0 -> stall=0 and regWriteEx=0.
REQ-039 Scenario – flush beats stall: load-use condition plus flush=1 -> stall=0, EX becomes a bubble next cycle, stall_count unchanged.
REQ-040 Scenario – saturation: force 65 537 stall cycles -> stall_count=16'hFFFF; then stall together with cnt_clear -> stall_count=0.
REQ-041 Scenario – asynchronous reset: assert rst between edges with all three stages valid -> all outputs read 0 before the next edge.

Source files
------------

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - EX/MEM/WB destination tags, load-use stall and stall counter
module hazard_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rd,
  input  logic        id_regWrite,
  input  logic        id_memRead,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        flush,
  input  logic        cnt_clear,
  output logic [4:0]  rdEx,
  output logic [4:0]  rdMem,
  output logic [4:0]  rdWb,
  output logic        regWriteEx,
  output logic        regWriteMem,
  output logic        regWriteWb,
  output logic        stall,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } tag_t;

  tag_t ex_tag, mem_tag, wb_tag;
  tag_t id_tag;
  logic raw_hazard;

  assign id_tag = '{valid: id_valid, rd: id_rd, regwrite: id_regWrite, memread: id_memRead};

  assign raw_hazard = id_valid & ex_tag.valid & ex_tag.memread & ex_tag.regwrite &
                      (ex_tag.rd != 5'd0) &
                      ((ex_tag.rd == id_rs1) | (ex_tag.rd == id_rs2));

  // Redirect wins: a wrong-path consumer must not cost a stall cycle.
  assign stall = raw_hazard & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag  <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else begin
      ex_tag  <= (flush | stall) ? tag_t'('0) : id_tag;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'd0;
    end else if (cnt_clear) begin
      stall_count <= 16'd0;
    end else if (stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign regWriteEx  = ex_tag.valid  & ex_tag.regwrite  & (ex_tag.rd  != 5'd0);
  assign regWriteMem = mem_tag.valid & mem_tag.regwrite & (mem_tag.rd != 5'd0);
  assign regWriteWb  = wb_tag.valid  & wb_tag.regwrite  & (wb_tag.rd  != 5'd0);

  assign rdEx  = ex_tag.valid  ? ex_tag.rd  : 5'd0;
  assign rdMem = mem_tag.valid ? mem_tag.rd : 5'd0;
  assign rdWb  = wb_tag.valid  ? wb_tag.rd  : 5'd0;

endmodule
